// File: rtl/sik_encoder_if.sv
// Command/output bundle for the SIK instruction encoder.
// The master side is the command source, which also acts as the word consumer.
// The slave side is the encoder itself.
interface sik_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_ext;
    logic [3:0]  in_op;
    logic [15:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_word;
    logic        out_pre;
    logic        err;
    logic [1:0]  err_code;
    logic [15:0] word_cnt;

    modport master (
        output in_valid, in_ext, in_op, in_imm, out_ready,
        input  in_ready, out_valid, out_word, out_pre, err, err_code, word_cnt
    );

    modport slave (
        input  in_valid, in_ext, in_op, in_imm, out_ready,
        output in_ready, out_valid, out_word, out_pre, err, err_code, word_cnt
    );
endinterface

// File: rtl/sik_encoder.sv
// SIK instruction encoder: turns {opcode, 16-bit immediate} commands into
// instruction words. An immediate that does not fit in 12 bits is preceded by
// a 0xF "pre" word that carries its upper nibble.
module sik_encoder #(
    parameter bit PRE_ALWAYS = 1'b0,
    parameter bit SIGNED_FIT = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    sik_encoder_if.slave  bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PRE  = 2'd1;
    localparam logic [1:0] ST_OP   = 2'd2;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_OPCODE = 2'd1;
    localparam logic [1:0] ERR_RANGE = 2'd2;

    logic [1:0]  state_q,    state_d;
    logic [15:0] out_word_q, out_word_d;
    logic        out_pre_q,  out_pre_d;
    logic [15:0] op_word_q,  op_word_d;
    logic        err_q,      err_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [15:0] word_cnt_q, word_cnt_d;

    logic        accept;
    logic        fire_out;
    logic [1:0]  cmd_err;
    logic        cmd_wide;
    logic        cmd_fits;
    logic        cmd_need_pre;
    logic [15:0] cmd_op_word;
    logic [15:0] cmd_pre_word;

    // Handshakes: a new command can enter when idle, or when the final word
    // of the current command retires this cycle.
    always_comb begin
        bus.in_ready  = (state_q == ST_IDLE) || ((state_q == ST_OP) && bus.out_ready);
        bus.out_valid = (state_q != ST_IDLE);
        accept        = bus.in_valid && bus.in_ready;
        fire_out      = bus.out_valid && bus.out_ready;
    end

    // Decode the presented command: legality, prefix need and encoded words.
    always_comb begin
        cmd_err  = ERR_NONE;
        cmd_wide = 1'b0;
        if (bus.in_ext) begin
            if ((bus.in_op == 4'h0) || (bus.in_op > 4'hC)) begin
                cmd_err = ERR_OPCODE;
            end
        end else begin
            if ((bus.in_op == 4'h0) || (bus.in_op > 4'h8)) begin
                cmd_err = ERR_OPCODE;
            end else if (bus.in_op <= 4'h3) begin
                // get/pop/put carry a 12-bit unsigned immediate only
                if (bus.in_imm[15:12] != 4'h0) begin
                    cmd_err = ERR_RANGE;
                end
            end else begin
                cmd_wide = 1'b1;
            end
        end

        if (SIGNED_FIT) begin
            cmd_fits = (bus.in_imm[15:12] == {4{bus.in_imm[11]}});
        end else begin
            cmd_fits = (bus.in_imm[15:12] == 4'h0);
        end
        cmd_need_pre = cmd_wide && (PRE_ALWAYS || !cmd_fits);

        if (bus.in_ext) begin
            cmd_op_word = {4'h0, 8'h00, bus.in_op};
        end else begin
            cmd_op_word = {bus.in_op, bus.in_imm[11:0]};
        end
        cmd_pre_word = {4'hF, 8'h00, bus.in_imm[15:12]};
    end

    // Next-state logic: retire words, sequence PRE -> OP, load new commands.
    always_comb begin
        state_d    = state_q;
        out_word_d = out_word_q;
        out_pre_d  = out_pre_q;
        op_word_d  = op_word_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        word_cnt_d = word_cnt_q;

        if (fire_out) begin
            word_cnt_d = word_cnt_q + 16'd1;
        end

        case (state_q)
            ST_PRE: begin
                // The op word always follows its prefix; no command can cut in.
                if (bus.out_ready) begin
                    state_d    = ST_OP;
                    out_word_d = op_word_q;
                    out_pre_d  = 1'b0;
                end
            end
            ST_OP: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Accept only happens in IDLE or when OP retires, so it overrides the
        // fall-back to IDLE above.
        if (accept) begin
            if (cmd_err != ERR_NONE) begin
                state_d    = ST_IDLE;
                err_d      = 1'b1;
                err_code_d = cmd_err;
            end else if (cmd_need_pre) begin
                state_d    = ST_PRE;
                out_word_d = cmd_pre_word;
                out_pre_d  = 1'b1;
                op_word_d  = cmd_op_word;
            end else begin
                state_d    = ST_OP;
                out_word_d = cmd_op_word;
                out_pre_d  = 1'b0;
            end
        end
    end

    // State registers with synchronous reset; reset discards any pending word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            out_word_q <= 16'h0000;
            out_pre_q  <= 1'b0;
            op_word_q  <= 16'h0000;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
            word_cnt_q <= 16'h0000;
        end else begin
            state_q    <= state_d;
            out_word_q <= out_word_d;
            out_pre_q  <= out_pre_d;
            op_word_q  <= op_word_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    // Drive registered outputs onto the bundle.
    always_comb begin
        bus.out_word = out_word_q;
        bus.out_pre  = out_pre_q;
        bus.err      = err_q;
        bus.err_code = err_code_q;
        bus.word_cnt = word_cnt_q;
    end

endmodule
